// File: rtl/alu_exec_unit_if.sv
// Handshake bus for the execute-stage ALU: operation request and registered result.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctr;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    // Upstream/downstream side: presents operations, consumes results.
    modport master (
        output in_valid, alu_ctr, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    // ALU side.
    modport slave (
        input  in_valid, alu_ctr, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides. Single-cycle ops land in
// HOLD on the next edge; sll/srl walk one bit per cycle in SHIFT first.
// SHAMT_W must equal log2(XLEN).
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    alu_exec_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_XOR = 4'b0010,
        OP_OR  = 4'b0011,
        OP_AND = 4'b0100,
        OP_NOT = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRL = 4'b0111,
        OP_SLT = 4'b1000
    } op_e;

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]    shreg_q, shreg_d;
    logic               dir_left_q, dir_left_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q, zero_d;

    op_e                op;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic               accept;
    logic [XLEN-1:0]    alu_out;
    logic [XLEN-1:0]    shreg_next;

    // Handshake outputs and operand decode.
    always_comb begin
        op            = op_e'(bus.alu_ctr);
        shamt         = bus.op_b[SHAMT_W-1:0];
        is_shift      = (op == OP_SLL) || (op == OP_SRL);
        bus.in_ready  = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
        accept        = bus.in_valid && bus.in_ready && !flush;
        bus.out_valid = (state_q == HOLD);
        bus.result    = result_q;
        bus.zero      = zero_q;
    end

    // Single-cycle datapath; shifts reaching here have shamt==0 and pass op_a through.
    always_comb begin
        alu_out = '0;
        case (op)
            OP_ADD:  alu_out = bus.op_a + bus.op_b;
            OP_SUB:  alu_out = bus.op_a - bus.op_b;
            OP_XOR:  alu_out = bus.op_a ^ bus.op_b;
            OP_OR:   alu_out = bus.op_a | bus.op_b;
            OP_AND:  alu_out = bus.op_a & bus.op_b;
            OP_NOT:  alu_out = ~bus.op_a;
            OP_SLL:  alu_out = bus.op_a;
            OP_SRL:  alu_out = bus.op_a;
            OP_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            default: alu_out = '0;
        endcase
    end

    // Next-state logic: accept, iterative shift, hold until consumed; flush squashes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        dir_left_d = dir_left_q;
        result_d   = result_q;
        zero_d     = zero_q;
        shreg_next = dir_left_q ? {shreg_q[XLEN-2:0], 1'b0} : {1'b0, shreg_q[XLEN-1:1]};

        case (state_q)
            IDLE, HOLD: begin
                if ((state_q == HOLD) && bus.out_ready) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        shreg_d    = bus.op_a;
                        cnt_d      = shamt;
                        dir_left_d = (op == OP_SLL);
                        state_d    = SHIFT;
                    end else begin
                        result_d = alu_out;
                        zero_d   = (alu_out == '0);
                        state_d  = HOLD;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shreg_next;
                cnt_d   = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = shreg_next;
                    zero_d   = (shreg_next == '0);
                    state_d  = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // State registers; synchronous reset dominates flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            dir_left_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            dir_left_q <= dir_left_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed scenarios plus a random stream
// checked against a behavioural model (result, zero flag, ordering, latency).
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int unsigned due;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_checks  = 0;
    int unsigned n_pass    = 0;
    int unsigned cyc       = 0;
    bit          head_seen = 1'b0;
    bit          force_rdy = 1'b1;
    bit          rdy_val   = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain arithmetic from the operation table.
    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return ~a;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (!rst && !flush && bus.out_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                if (!head_seen) begin
                    check("latency", cyc, sbq[0].due);
                    head_seen = 1'b1;
                end
                check("result", bus.result, sbq[0].res);
                check("zero", 32'(bus.zero), 32'(sbq[0].zero));
                if (bus.out_ready) begin
                    void'(sbq.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    task automatic drive_rdy();
        bus.out_ready = force_rdy ? rdy_val : ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            drive_rdy();
        end
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int unsigned waits);
        exp_t e;
        waits = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctr  = c;
        bus.op_a     = a;
        bus.op_b     = b;
        drive_rdy();
        #1;
        while (!bus.in_ready) begin
            waits++;
            if (waits > 100) begin
                check("accept_timeout", waits, 32'd0);
                break;
            end
            @(negedge clk);
            drive_rdy();
            #1;
        end
        if (bus.in_ready) begin
            e.res  = ref_result(c, a, b);
            e.zero = (e.res == 32'd0);
            e.due  = cyc + 1 + (((c == 4'd6) || (c == 4'd7)) ? int'(b[4:0]) : 0);
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int unsigned n;
        n         = 0;
        force_rdy = 1'b1;
        rdy_val   = 1'b1;
        while ((sbq.size() != 0) && (n < 200)) begin
            idle(1);
            #3;
            n++;
        end
        check("drain_empty", sbq.size(), 32'd0);
    endtask

    // Squash cycle for rst or flush: expectations in flight are dropped.
    task automatic squash(input bit use_rst);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        #3;
        sbq.delete();
        head_seen = 1'b0;
        @(negedge clk);
        rst          = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check(use_rst ? "rst_out_valid" : "flush_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned w;
        logic [3:0]  c;
        logic [31:0] a, b;

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_ctr   = '0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;

        // 1: reset, then add
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_zero", 32'(bus.zero), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        send(4'd0, 32'd7, 32'd5, w);
        check("add_no_stall", w, 32'd0);

        // 2: sub to zero, slt signed, long sll
        send(4'd1, 32'h1234, 32'h1234, w);
        check("sub_no_stall", w, 32'd0);
        send(4'd8, 32'hFFFF_FFFF, 32'd1, w);
        check("slt_no_stall", w, 32'd0);
        send(4'd6, 32'd1, 32'd31, w);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            check("shift_in_ready", 32'(bus.in_ready), 32'd0);
        end
        drain();

        // 3: back-pressure on xor, then or accepted with no bubble
        rdy_val = 1'b0;
        send(4'd2, 32'hA5A5_A5A5, 32'h0F0F_0F0F, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.alu_ctr   = 4'd3;
            bus.op_a      = 32'h1200_0034;
            bus.op_b      = 32'h0056_0000;
            bus.out_ready = 1'b0;
            #1;
            check("backpressure_in_ready", 32'(bus.in_ready), 32'd0);
        end
        rdy_val = 1'b1;
        send(4'd3, 32'h1200_0034, 32'h0056_0000, w);
        check("no_bubble", w, 32'd0);
        drain();

        // 4: flush during SHIFT, then during HOLD with a request present
        send(4'd7, 32'h8000_0000, 32'd4, w);
        idle(1);
        bus.in_valid = 1'b1;
        squash(1'b0);
        idle(6);
        send(4'd0, 32'd3, 32'd4, w);
        check("post_flush_accept", w, 32'd0);
        drain();
        rdy_val = 1'b0;
        send(4'd0, 32'd10, 32'd20, w);
        idle(1);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        squash(1'b0);
        idle(4);
        drain();

        // 5: reset mid-SHIFT and during HOLD, undefined code
        send(4'd6, 32'd3, 32'd20, w);
        idle(3);
        squash(1'b1);
        check("rst_shift_result", bus.result, 32'd0);
        rdy_val = 1'b0;
        send(4'd0, 32'd1, 32'd2, w);
        idle(2);
        squash(1'b1);
        check("rst_hold_result", bus.result, 32'd0);
        check("rst_hold_zero", 32'(bus.zero), 32'd0);
        rdy_val = 1'b1;
        send(4'hF, $urandom, $urandom, w);
        drain();

        // 6: random stream with random back-pressure
        force_rdy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            c = 4'($urandom_range(0, 9));
            if (c == 4'd9) c = 4'($urandom_range(9, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = a;
                2: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            send(c, a, b, w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
